// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between the execute stage (port 0)
// and the address/branch-target unit (port 1), with a one-deep registered response.
module alu_share_arbiter #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,

    input  logic             req0_valid,
    input  logic [4:0]       req0_op,
    input  logic [1:0]       req0_funct,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic [4:0]       req1_op,
    input  logic [1:0]       req1_funct,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,

    output logic [4:0]       alu_op,
    output logic [1:0]       alu_funct,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_ofl,

    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_ofl,
    input  logic             rsp_ready,

    output logic [CNTW-1:0]  gnt_cnt0,
    output logic [CNTW-1:0]  gnt_cnt1,
    output logic [CNTW-1:0]  stall_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;
    logic   last;
    logic   gnt_any;
    logic   gnt_id;
    logic   can_accept;
    logic   accept;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Tie goes to the port that did not win the previous accept.
    always_comb begin
        gnt_any = req0_valid || req1_valid;
        gnt_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_id = ~last;
        end else if (req1_valid) begin
            gnt_id = 1'b1;
        end
    end

    assign can_accept = !flush && (state == EMPTY || rsp_ready);
    assign accept     = can_accept && gnt_any;
    assign req0_ready = accept && !gnt_id;
    assign req1_ready = accept &&  gnt_id;

    // The ALU sees the granted operation even while the response slot is blocked.
    always_comb begin
        alu_op    = '0;
        alu_funct = '0;
        alu_a     = '0;
        alu_b     = '0;
        if (gnt_any) begin
            if (gnt_id) begin
                alu_op    = req1_op;
                alu_funct = req1_funct;
                alu_a     = req1_a;
                alu_b     = req1_b;
            end else begin
                alu_op    = req0_op;
                alu_funct = req0_funct;
                alu_a     = req0_a;
                alu_b     = req0_b;
            end
        end
    end

    assign rsp_valid = (state == FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_ofl   <= 1'b0;
            last      <= 1'b1;
            gnt_cnt0  <= '0;
            gnt_cnt1  <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept) begin
                state    <= FULL;
                rsp_id   <= gnt_id;
                rsp_data <= alu_out;
                rsp_ofl  <= alu_ofl;
                last     <= gnt_id;
                if (gnt_id) begin
                    gnt_cnt1 <= sat_inc(gnt_cnt1);
                end else begin
                    gnt_cnt0 <= sat_inc(gnt_cnt0);
                end
            end else if (flush || rsp_ready) begin
                state <= EMPTY;
            end

            if (gnt_any && !accept) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

endmodule
